// File: rtl/icdc_mem_arbiter.sv
// Round-robin arbiter sharing one DRAM command/response channel between I-cache and D-cache.
// Define ARB_TIMEOUT_EN to add a response watchdog that releases a stalled read and flags arb_err.
module icdc_mem_arbiter #(
  parameter int unsigned TMO_WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ic_req,
  input  logic [27:0]  ic_adr,
  output logic         ic_done,
  input  logic         dc_req,
  input  logic         dc_we,
  input  logic [27:0]  dc_adr,
  input  logic [127:0] dc_wdata,
  output logic         dc_done,
  output logic         m_cmd_valid,
  input  logic         m_cmd_ready,
  output logic         m_cmd_we,
  output logic [27:0]  m_cmd_adr,
  output logic [127:0] m_wdata,
  input  logic         m_rdat_valid,
  input  logic [127:0] m_rdat_data,
  output logic         ic_rdat_valid,
  output logic         dc_rdat_valid,
  output logic [127:0] rdat_data,
  output logic         arb_busy,
  output logic         arb_err
);

  // StDack holds the write-accept pulse so the still-raised dc_req is not re-granted.
  typedef enum logic [2:0] {StIdle, StIcmd, StIwait, StDcmd, StDwait, StDack} state_e;

  state_e         state_q, state_d;
  logic           last_dc_q, last_dc_d;
  logic           cmd_we_q, cmd_we_d;
  logic [27:0]    cmd_adr_q, cmd_adr_d;
  logic [127:0]   wdata_q, wdata_d;
  logic           tmo_hit;

`ifdef ARB_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic                 waiting;

  assign waiting = (state_q == StIwait) || (state_q == StDwait);
  assign tmo_hit = waiting && (&tmo_q);

  always_comb begin
    tmo_d = '0;
    err_d = err_q;
    if (waiting) tmo_d = tmo_q + TMO_WIDTH'(1);
    if (tmo_hit && !m_rdat_valid) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign arb_err = err_q;
`else
  logic [31:0] unused_tmo_width;

  assign unused_tmo_width = 32'(TMO_WIDTH);
  assign tmo_hit          = 1'b0;
  assign arb_err          = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    last_dc_d     = last_dc_q;
    cmd_we_d      = cmd_we_q;
    cmd_adr_d     = cmd_adr_q;
    wdata_d       = wdata_q;
    m_cmd_valid   = 1'b0;
    ic_rdat_valid = 1'b0;
    dc_rdat_valid = 1'b0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    unique case (state_q)
      StIdle: begin
        // On a tie the side that did not win last time gets the grant.
        if (dc_req && (!ic_req || !last_dc_q)) begin
          state_d   = StDcmd;
          last_dc_d = 1'b1;
          cmd_we_d  = dc_we;
          cmd_adr_d = dc_adr;
          wdata_d   = dc_wdata;
        end else if (ic_req) begin
          state_d   = StIcmd;
          last_dc_d = 1'b0;
          cmd_we_d  = 1'b0;
          cmd_adr_d = ic_adr;
          wdata_d   = '0;
        end
      end
      StIcmd: begin
        m_cmd_valid = 1'b1;
        if (m_cmd_ready) state_d = StIwait;
      end
      StIwait: begin
        ic_rdat_valid = m_rdat_valid;
        if (m_rdat_valid || tmo_hit) begin
          ic_done = 1'b1;
          state_d = StIdle;
        end
      end
      StDcmd: begin
        m_cmd_valid = 1'b1;
        if (m_cmd_ready) state_d = cmd_we_q ? StDack : StDwait;
      end
      StDwait: begin
        dc_rdat_valid = m_rdat_valid;
        if (m_rdat_valid || tmo_hit) begin
          dc_done = 1'b1;
          state_d = StIdle;
        end
      end
      StDack: begin
        dc_done = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_dc_q <= 1'b0;
      cmd_we_q  <= 1'b0;
      cmd_adr_q <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_dc_q <= last_dc_d;
      cmd_we_q  <= cmd_we_d;
      cmd_adr_q <= cmd_adr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign m_cmd_we  = cmd_we_q;
  assign m_cmd_adr = cmd_adr_q;
  assign m_wdata   = wdata_q;
  assign rdat_data = m_rdat_data;
  assign arb_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_icdc_mem_arbiter.sv
// Scoreboard bench for icdc_mem_arbiter: directed corner cases, then randomized rounds of
// I/D requests against a transaction-level round-robin model and a behavioural memory.
module tb_icdc_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req, dc_req, dc_we;
  logic [27:0]  ic_adr, dc_adr;
  logic [127:0] dc_wdata;
  logic         ic_done, dc_done;
  logic         m_cmd_valid, m_cmd_ready, m_cmd_we;
  logic [27:0]  m_cmd_adr;
  logic [127:0] m_wdata;
  logic         m_rdat_valid;
  logic [127:0] m_rdat_data;
  logic         ic_rdat_valid, dc_rdat_valid;
  logic [127:0] rdat_data;
  logic         arb_busy, arb_err;

  always #5 clk = ~clk;

  icdc_mem_arbiter #(.TMO_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_adr(ic_adr), .ic_done(ic_done),
    .dc_req(dc_req), .dc_we(dc_we), .dc_adr(dc_adr), .dc_wdata(dc_wdata), .dc_done(dc_done),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_we(m_cmd_we),
    .m_cmd_adr(m_cmd_adr), .m_wdata(m_wdata),
    .m_rdat_valid(m_rdat_valid), .m_rdat_data(m_rdat_data),
    .ic_rdat_valid(ic_rdat_valid), .dc_rdat_valid(dc_rdat_valid), .rdat_data(rdat_data),
    .arb_busy(arb_busy), .arb_err(arb_err)
  );

  // side: 0 = icache, 1 = dcache
  typedef struct packed {
    logic         side;
    logic         we;
    logic [27:0]  adr;
    logic [127:0] wdata;
  } txn_t;

  txn_t cmd_q[$];
  txn_t done_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   mon_en  = 1'b0;
  bit   mem_en  = 1'b0;
  logic last_dc_m;

  function automatic logic [127:0] mem_data(input logic [27:0] a);
    return {4{4'hA, a}} ^ 128'h5A5A_0F0F_3C3C_9696_A5A5_F0F0_C3C3_6969;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input txn_t t);
    cmd_q.push_back(t);
    done_q.push_back(t);
    last_dc_m = t.side;
  endtask

  task automatic monitor();
    txn_t t;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (m_cmd_valid) begin
          if (cmd_q.size() == 0) check("cmd_unexpected", m_cmd_valid, 1'b0);
          else begin
            t = cmd_q[0];
            check("cmd_we", m_cmd_we, t.we);
            check("cmd_adr", m_cmd_adr, t.adr);
            if (t.we) check("cmd_wdata", m_wdata, t.wdata);
            if (m_cmd_ready) void'(cmd_q.pop_front());
          end
        end
        if (ic_done || dc_done) begin
          if (done_q.size() == 0) check("done_unexpected", {ic_done, dc_done}, 2'b00);
          else begin
            t = done_q.pop_front();
            check("done_side", {ic_done, dc_done}, t.side ? 2'b01 : 2'b10);
            if (!t.we) begin
              check("rdat_strobe", {ic_rdat_valid, dc_rdat_valid}, t.side ? 2'b01 : 2'b10);
              check("rdat_data", rdat_data, mem_data(t.adr));
            end else begin
              check("wr_no_strobe", {ic_rdat_valid, dc_rdat_valid}, 2'b00);
            end
          end
        end else begin
          check("rdat_no_done", {ic_rdat_valid, dc_rdat_valid}, 2'b00);
        end
      end
    end
  endtask

  // Memory: random ready, one read beat after a random delay, stray beats when no read pending.
  task automatic mem_responder();
    bit          rd_pend = 1'b0;
    int          rd_dly  = 0;
    logic [27:0] rd_adr  = '0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (rd_pend && m_rdat_valid) rd_pend = 1'b0;
        if (m_cmd_valid && m_cmd_ready && !m_cmd_we) begin
          rd_pend = 1'b1;
          rd_dly  = $urandom_range(0, 4);
          rd_adr  = m_cmd_adr;
        end
        @(posedge clk);
        #1;
        m_cmd_ready  = ($urandom_range(0, 2) != 0);
        m_rdat_valid = 1'b0;
        if (rd_pend) begin
          if (rd_dly == 0) begin
            m_rdat_valid = 1'b1;
            m_rdat_data  = mem_data(rd_adr);
          end else rd_dly--;
        end else if ($urandom_range(0, 5) == 0) begin
          m_rdat_valid = 1'b1;
          m_rdat_data  = {4{$urandom}};
        end
      end
    end
  endtask

  task automatic drive_ic(input logic [27:0] adr, output bit ok);
    ok     = 1'b0;
    ic_adr = adr;
    ic_req = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ic_done) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    ic_req = 1'b0;
  endtask

  task automatic drive_dc(input txn_t t, output bit ok);
    ok       = 1'b0;
    dc_we    = t.we;
    dc_adr   = t.adr;
    dc_wdata = t.wdata;
    dc_req   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dc_done) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    dc_req = 1'b0;
  endtask

  task automatic run_round(input bit do_ic, input bit do_dc, input bit dwe);
    txn_t ti, td;
    bit   ok_i, ok_d;
    ti = '{side: 1'b0, we: 1'b0, adr: 28'($urandom), wdata: '0};
    td = '{side: 1'b1, we: dwe, adr: 28'($urandom),
           wdata: dwe ? {$urandom, $urandom, $urandom, $urandom} : 128'h0};
    // Model: a tie goes to whichever side was not granted most recently.
    if (do_ic && do_dc) begin
      if (last_dc_m) begin
        push_txn(ti);
        push_txn(td);
      end else begin
        push_txn(td);
        push_txn(ti);
      end
    end else if (do_ic) push_txn(ti);
    else if (do_dc) push_txn(td);
    ok_i = 1'b0;
    ok_d = 1'b0;
    fork
      if (do_ic) drive_ic(ti.adr, ok_i);
      if (do_dc) drive_dc(td, ok_d);
    join
    if (do_ic) check("ic_done_timeout", ok_i, 1'b1);
    if (do_dc) check("dc_done_timeout", ok_d, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_adr = '0; dc_adr = '0; dc_wdata = '0;
    m_cmd_ready = 1'b0; m_rdat_valid = 1'b0; m_rdat_data = '0;
    fork
      monitor();
      mem_responder();
    join_none

    repeat (2) @(negedge clk);
    check("rst_cmd_valid", m_cmd_valid, 1'b0);
    check("rst_busy", arb_busy, 1'b0);
    check("rst_err", arb_err, 1'b0);
    check("rst_dones", {ic_done, dc_done, ic_rdat_valid, dc_rdat_valid}, 4'b0);
    check("rst_cmd_regs", {m_cmd_we, m_cmd_adr, m_wdata}, '0);
    step();
    rst_n = 1'b1;

    // IC refill, response three cycles after the command.
    step();
    ic_adr = 28'h0000100; ic_req = 1'b1; m_cmd_ready = 1'b1;
    @(negedge clk); check("ic_grant_cycle_n", m_cmd_valid, 1'b0);
    @(negedge clk);
    check("ic_cmd_valid", m_cmd_valid, 1'b1);
    check("ic_cmd_we", m_cmd_we, 1'b0);
    check("ic_cmd_adr", m_cmd_adr, 28'h0000100);
    check("ic_busy", arb_busy, 1'b1);
    step(); m_cmd_ready = 1'b0;
    @(negedge clk); check("ic_wait_no_done", ic_done, 1'b0);
    step();
    step(); m_rdat_valid = 1'b1; m_rdat_data = {16{8'hA5}};
    @(negedge clk);
    check("ic_rdat_valid", ic_rdat_valid, 1'b1);
    check("ic_done", ic_done, 1'b1);
    check("ic_rdat_data", rdat_data, {16{8'hA5}});
    check("ic_no_dc_strobe", dc_rdat_valid, 1'b0);
    step(); m_rdat_valid = 1'b0; ic_req = 1'b0;
    @(negedge clk); check("ic_back_idle", {arb_busy, ic_done}, 2'b00);

    // DC writeback with ready withheld for four cycles.
    step();
    dc_req = 1'b1; dc_we = 1'b1; dc_adr = 28'h0000200; dc_wdata = 128'h1234;
    @(negedge clk); check("dc_grant_cycle_n", m_cmd_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dc_cmd_stable", {m_cmd_valid, m_cmd_we, m_cmd_adr, m_wdata},
            {1'b1, 1'b1, 28'h0000200, 128'h1234});
    end
    step(); m_cmd_ready = 1'b1;
    @(negedge clk); check("dc_done_not_on_ready", dc_done, 1'b0);
    step(); m_cmd_ready = 1'b0;
    @(negedge clk);
    check("dc_wr_done", dc_done, 1'b1);
    check("dc_wr_no_cmd", m_cmd_valid, 1'b0);
    check("dc_wr_no_strobe", dc_rdat_valid, 1'b0);
    step(); dc_req = 1'b0; dc_we = 1'b0;
    @(negedge clk); check("dc_back_idle", {arb_busy, dc_done}, 2'b00);

    // Stray read beat while idle.
    step(); m_rdat_valid = 1'b1; m_rdat_data = {4{32'hDEAD_BEEF}};
    @(negedge clk);
    check("idle_stray_strobes", {ic_rdat_valid, dc_rdat_valid, ic_done, dc_done}, 4'b0);
    check("idle_stray_busy", arb_busy, 1'b0);
    step(); m_rdat_valid = 1'b0;
    @(negedge clk); check("idle_stray_after", arb_busy, 1'b0);

    // Asynchronous reset while waiting for IC read data.
    step(); ic_adr = 28'h0000300; ic_req = 1'b1; m_cmd_ready = 1'b1;
    step();
    step(); m_cmd_ready = 1'b0;
    @(negedge clk); check("iwait_busy", arb_busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", arb_busy, 1'b0);
    check("rst_mid_outs", {m_cmd_valid, ic_done, dc_done, ic_rdat_valid, m_cmd_adr}, '0);
    ic_req = 1'b0;
    step(); rst_n = 1'b1; m_rdat_valid = 1'b1; m_rdat_data = mem_data(28'h0000300);
    @(negedge clk);
    check("rst_late_beat", {ic_rdat_valid, ic_done, arb_busy}, 3'b000);
    step(); m_rdat_valid = 1'b0;

    // Randomized phase from a fresh reset so the first tie goes to the dcache.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    last_dc_m = 1'b0;
    mon_en = 1'b1;
    mem_en = 1'b1;
    for (int r = 0; r < 3; r++) run_round(1'b1, 1'b1, 1'(r == 1));
    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      repeat ($urandom_range(0, 3)) step();
      run_round(sel[0], sel[1], 1'($urandom_range(0, 1)));
    end
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    mem_en = 1'b0;
    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);
    check("final_err", arb_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
